// File: rtl/sort_host.sv
// Host sequencer for a shared-memory sorter: streams N elements in, hands the memory to the sorter, then streams the result out.
// Load accepts 1 element/cycle; readout costs 3 cycles/element and holds out_data while out_ready is low.
module sort_host #(
  parameter int N  = 8,
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          sort_start,
  input  logic          sort_done,
  output logic          mem_sel,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [2:0] {
    IDLE, LOAD, START, WAIT, RELEASE, RD_REQ, RD_CAP, RD_OUT
  } state_t;

  localparam logic [AW:0] LAST = (AW+1)'(N - 1);

  state_t        state, state_nxt;
  logic [AW:0]   cnt, cnt_nxt;
  logic [DW-1:0] out_data_q;

  logic          in_ready_c;
  logic          out_valid_c;
  logic          sort_start_c;
  logic          sel_c;
  logic          we_c;
  logic [AW-1:0] addr_c;
  logic [DW-1:0] wdata_c;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      out_data_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      // Read data is valid one cycle after RD_REQ presented the address.
      if (state == RD_CAP) out_data_q <= mem_rdata;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    in_ready_c   = 1'b0;
    out_valid_c  = 1'b0;
    sort_start_c = 1'b0;
    sel_c        = 1'b1;
    we_c         = 1'b0;
    addr_c       = '0;
    wdata_c      = '0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (in_valid) state_nxt = LOAD;
      end
      LOAD: begin
        in_ready_c = 1'b1;
        addr_c     = cnt[AW-1:0];
        if (in_valid) begin
          we_c    = 1'b1;
          wdata_c = in_data;
          if (cnt == LAST) begin
            cnt_nxt   = '0;
            state_nxt = START;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      START: begin
        sel_c        = 1'b0;
        sort_start_c = 1'b1;
        state_nxt    = WAIT;
      end
      WAIT: begin
        sel_c        = 1'b0;
        sort_start_c = 1'b1;
        if (sort_done) state_nxt = RELEASE;
      end
      RELEASE: begin
        // Reclaim the memory only after the sorter has dropped done.
        sel_c = 1'b0;
        if (!sort_done) state_nxt = RD_REQ;
      end
      RD_REQ: begin
        addr_c    = cnt[AW-1:0];
        state_nxt = RD_CAP;
      end
      RD_CAP: begin
        addr_c    = cnt[AW-1:0];
        state_nxt = RD_OUT;
      end
      RD_OUT: begin
        addr_c      = cnt[AW-1:0];
        out_valid_c = 1'b1;
        if (out_ready) begin
          if (cnt == LAST) begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt   = cnt + 1'b1;
            state_nxt = RD_REQ;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reset overrides the decoded outputs so nothing leaks while rst is low.
  assign in_ready   = rst & in_ready_c;
  assign out_valid  = rst & out_valid_c;
  assign sort_start = rst & sort_start_c;
  assign mem_sel    = ~rst | sel_c;
  assign mem_we     = rst & we_c;
  assign mem_addr   = rst ? addr_c : '0;
  assign mem_wdata  = rst ? wdata_c : '0;
  assign busy       = rst & (state != IDLE);
  assign out_data   = out_data_q;

endmodule

// File: tb/tb_sort_host.sv
// Bench for sort_host: behavioural shared memory and sorter, directed table plus random jobs.
module tb_sort_host;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 2;

  typedef logic [N-1:0][DW-1:0] arr_t;

  typedef struct {
    arr_t d;
    arr_t exp;
    bit   gap;
    int   delay;
    int   hold;
    int   stall;
    bit   abort;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic          sort_start;
  logic          sort_done = 1'b0;
  logic          mem_sel;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  logic          do_sort = 1'b0;
  arr_t          mem;

  int n_cmp = 0;
  int n_err = 0;
  int we_viol = 0;

  always #5 clk = ~clk;

  sort_host #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .sort_start(sort_start), .sort_done(sort_done),
    .mem_sel(mem_sel), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  function automatic arr_t bubble(input arr_t a);
    logic [DW-1:0] t;
    for (int i = 0; i < N - 1; i++)
      for (int j = 0; j < N - 1 - i; j++)
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    return a;
  endfunction

  // Shared memory with registered read; the sorter rewrites it in place when told to.
  always @(posedge clk) begin
    if (do_sort) mem <= bubble(mem);
    else if (mem_sel && mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  function automatic arr_t ref_sort(input arr_t d);
    int q[$];
    arr_t r;
    for (int i = 0; i < N; i++) q.push_back(int'(d[i]));
    q.sort();
    for (int i = 0; i < N; i++) r[i] = DW'(q[i]);
    return r;
  endfunction

  function automatic arr_t pack4(input int e0, input int e1, input int e2, input int e3);
    arr_t r;
    r[0] = DW'(e0); r[1] = DW'(e1); r[2] = DW'(e2); r[3] = DW'(e3);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic iv, input logic [DW-1:0] id, input logic ordy,
                      input logic sd, input logic ds);
    @(negedge clk);
    in_valid = iv; in_data = id; out_ready = ordy; sort_done = sd; do_sort = ds;
    #1;
    if (mem_we && !mem_sel) we_viol++;
  endtask

  task automatic run_job(input vec_t v);
    int acc = 0;
    int c = 0;
    int spurious = 0;
    int viol = 0;
    logic iv;
    // Load phase
    while (acc < N && c < 60) begin
      iv = v.gap ? (c % 2 == 0) : 1'b1;
      step(iv, v.d[acc], 1'b0, 1'b0, 1'b0);
      c++;
      if (in_ready && iv) begin
        check("load_we", 32'(mem_we), 1);
        check("load_addr", 32'(mem_addr), acc);
        check("load_wdata", 32'(mem_wdata), 32'(v.d[acc]));
        acc++;
      end else if (mem_we) begin
        spurious++;
      end
    end
    check("load_count", acc, N);
    check("load_spurious_we", spurious, 0);
    // START
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("start_outs", 32'({sort_start, mem_sel, in_ready, busy}), 32'(4'b1001));
    if (v.abort) begin
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      check("wait_before_abort", 32'(sort_start), 1);
      @(negedge clk); rst = 1'b0; #1;
      check("abort_comb", 32'({sort_start, busy, in_ready, mem_sel}), 32'(4'b0001));
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      check("abort_edge", 32'({sort_start, busy, in_ready, mem_sel, out_valid, mem_we}), 32'(6'b000100));
      check("abort_out_data", 32'(out_data), 0);
      @(negedge clk); rst = 1'b1;
      return;
    end
    // WAIT with sorter busy
    for (int k = 0; k < v.delay; k++) begin
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      if (!(sort_start && !mem_sel && busy && !out_valid)) viol++;
    end
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    if (!(sort_start && !mem_sel)) viol++;
    check("wait_hold", viol, 0);
    viol = 0;
    for (int h = 0; h < v.hold; h++) begin
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      if (h == 0 && !(sort_start && !mem_sel)) viol++;
      if (h > 0 && !(!sort_start && !mem_sel && !out_valid)) viol++;
    end
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    if (!(!sort_start && !mem_sel)) viol++;
    check("release_hold", viol, 0);
    // Readout: RD_REQ, RD_CAP, RD_OUT per element
    for (int j = 0; j < N; j++) begin
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      check("rd_req", 32'({out_valid, mem_sel, mem_we, mem_addr}), 32'({1'b0, 1'b1, 1'b0, AW'(j)}));
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      check("rd_cap_valid", 32'(out_valid), 0);
      if (j == 1) begin
        viol = 0;
        for (int s = 0; s < v.stall; s++) begin
          step(1'b0, '0, 1'b0, 1'b0, 1'b0);
          if (!out_valid || out_data !== v.exp[j]) viol++;
        end
        check("stall_hold", viol, 0);
      end
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      check("out_valid", 32'(out_valid), 1);
      check("out_data", 32'(out_data), 32'(v.exp[j]));
    end
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("idle_after", 32'({busy, out_valid, mem_sel}), 32'(3'b001));
  endtask

  vec_t tbl[14];

  initial begin
    tbl[0] = '{pack4(3,1,4,2),     pack4(1,2,3,4),     1'b0, 2,   1, 0, 1'b0};
    tbl[1] = '{pack4(3,1,4,2),     pack4(1,2,3,4),     1'b1, 1,   1, 0, 1'b0};
    tbl[2] = '{pack4(9,8,7,6),     pack4(6,7,8,9),     1'b0, 100, 1, 0, 1'b0};
    tbl[3] = '{pack4(5,250,0,5),   pack4(0,5,5,250),   1'b0, 0,   1, 5, 1'b0};
    tbl[4] = '{pack4(1,2,3,4),     pack4(1,2,3,4),     1'b0, 3,   3, 0, 1'b0};
    tbl[5] = '{pack4(10,20,30,40), pack4(10,20,30,40), 1'b0, 0,   1, 0, 1'b1};
    tbl[6] = '{pack4(7,7,0,255),   pack4(0,7,7,255),   1'b0, 1,   1, 0, 1'b0};
    for (int i = 7; i < 14; i++) begin
      tbl[i].d     = pack4(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                           int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      tbl[i].exp   = ref_sort(tbl[i].d);
      tbl[i].gap   = 1'($urandom_range(0, 1));
      tbl[i].delay = int'($urandom_range(0, 6));
      tbl[i].hold  = int'($urandom_range(1, 3));
      tbl[i].stall = int'($urandom_range(0, 3));
      tbl[i].abort = 1'b0;
    end

    step(1'b1, 8'd55, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'd55, 1'b1, 1'b0, 1'b0);
    check("rst_outs", 32'({in_ready, out_valid, sort_start, mem_sel, mem_we, busy}), 32'(6'b000100));
    check("rst_out_data", 32'(out_data), 0);
    check("rst_mem_bus", 32'({mem_addr, mem_wdata}), 0);
    @(negedge clk); in_valid = 1'b0; rst = 1'b1;

    for (int i = 0; i < 14; i++) run_job(tbl[i]);

    check("we_while_unowned", we_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sort_host.md
SORT_HOST -- requirements
Module: sort_host

Interface
REQ-001 SHALL have parameter N, default 8: number of elements per sort job, N >= 2.
REQ-002 SHALL have parameter DW, default 8: element data width.
REQ-003 SHALL have parameter AW, default 3: memory address width, equal to clog2(N).
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-low reset (one clock; reset is synchronous and active-low).
REQ-006 SHALL have port in_valid, input, 1: load-stream element valid.
REQ-007 SHALL have port in_data, input, DW: load-stream element.
REQ-008 SHALL have port in_ready, output, 1: load-stream element accepted when in_valid and in_ready are both 1.
REQ-009 SHALL have port out_valid, output, 1: result-stream element valid.
REQ-010 SHALL have port out_data, output, DW: result-stream element, registered.
REQ-011 SHALL have port out_ready, input, 1: result-stream consumer ready.
REQ-012 SHALL have port sort_start, output, 1: start request to the sort controller.
REQ-013 SHALL have port sort_done, input, 1: done indication from the sort controller.
REQ-014 SHALL have port mem_sel, output, 1: 1 = host owns the shared memory port, 0 = sorter owns it.
REQ-015 SHALL have port mem_we, output, 1: memory write strobe.
REQ-016 SHALL have port mem_addr, output, AW: memory address.
REQ-017 SHALL have port mem_wdata, output, DW: memory write data.
REQ-018 SHALL have port mem_rdata, input, DW: memory read data, valid one cycle after its address is presented.
REQ-019 SHALL have port busy, output, 1: 1 in every state except IDLE.

Function
REQ-020 SHALL implement FSM states IDLE, LOAD, START, WAIT, RELEASE, RD_REQ, RD_CAP, RD_OUT, plus an element counter cnt of width AW+1.
REQ-021 IDLE: in_ready=0, mem_sel=1, cnt cleared to 0; go to LOAD when in_valid=1, without consuming the element.
REQ-022 LOAD: in_ready=1, mem_sel=1; on each accepted element, drive mem_we=1, mem_addr=cnt[AW-1:0], mem_wdata=in_data combinationally in that same cycle, and increment cnt.
REQ-023 LOAD: when cnt==N-1 is accepted, clear cnt to 0 and go to START; while in_valid=0, stay in LOAD with no write.
REQ-024 START: mem_sel=0, sort_start=1, in_ready=0; go to WAIT unconditionally after one cycle.
REQ-025 WAIT: mem_sel=0, sort_start=1; stay while sort_done=0; go to RELEASE when sort_done=1; no timeout.
REQ-026 RELEASE: mem_sel=0, sort_start=0; stay while sort_done=1; go to RD_REQ when sort_done=0, i.e. once the sorter has returned to its idle state.
REQ-027 RD_REQ: mem_sel=1, mem_addr=cnt[AW-1:0], mem_we=0; go to RD_CAP.
REQ-028 RD_CAP: register mem_rdata into out_data on the exiting edge; go to RD_OUT.
REQ-029 RD_OUT: out_valid=1 with out_data held stable until out_ready=1.
REQ-030 RD_OUT on handshake: if cnt==N-1, go to IDLE; otherwise increment cnt and go to RD_REQ.
REQ-031 A handshake SHALL complete in the first RD_OUT cycle when out_ready is already 1.
REQ-032 out_valid SHALL be 0 in every state except RD_OUT.
REQ-033 mem_we SHALL be 1 only on an accepted LOAD element, and never while mem_sel=0.
REQ-034 When mem_sel=0, mem_addr and mem_wdata SHALL be driven 0.
REQ-035 No element SHALL be accepted outside LOAD; in_valid in any other state SHALL be ignored.
REQ-036 Throughput SHALL be 1 element/cycle on load and 1 element per 3 cycles on readout.

Reset
REQ-037 On a rising clk edge with rst=0, the block SHALL go to IDLE with cnt=0 and out_data=0.
REQ-038 While in reset, all outputs SHALL be 0 except mem_sel=1.
REQ-039 Reset asserted mid-operation (any state) SHALL drop sort_start and out_valid on the next edge, with no further memory writes.

Verification
REQ-040 N=4, DW=8, stream 3,1,4,2 with in_valid always 1, behavioural sorter -> writes at addresses 0..3, sort_start high from START until sort_done, output stream 1,2,3,4, then IDLE with busy=0.
REQ-041 Load with in_valid toggling 1,0,1,0 -> writes occur only in cycles where in_valid=1; addresses are consecutive 0..3 with no gaps.
REQ-042 sort_done delayed 100 cycles after START -> sort_start stays 1 throughout, mem_sel stays 0, and no mem_we pulse occurs.
REQ-043 out_ready held 0 for 5 cycles in RD_OUT -> out_valid stays 1, out_data is unchanged, and cnt does not advance.
REQ-044 rst=0 during WAIT -> next edge shows sort_start=0, busy=0, in_ready=0, mem_sel=1; a fresh job of 7,7,0,255 then sorts to 0,7,7,255.
REQ-045 sort_done held 1 for 3 cycles after the first assertion -> block stays in RELEASE, with the first RD_REQ 1 cycle after sort_done falls.
